// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder
//   On-chip operand source for the mac. A host loads one signal vector and one
//   coefficient vector into local buffers. A start pulse then streams both
//   vectors, in ascending address order, into the mac's signal and coefficient
//   FIFOs using wr_en / last / idle signalling. The stream stalls on full_mul.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cfg_we_i/sel/addr/data  host buffer write port (sel 0 = signal, 1 = coeff);
//                           writes are dropped while busy_o is high
//   sig_count_i             number of signal words to send on start
//   coeff_count_i           number of coefficient words to send on start
//   start_i                 one-cycle start pulse, ignored while busy_o is high
//   full_mul                almost-full back-pressure from the mac
//   signal_fifo, wr_en_signal, last_signal, idle_signal   signal stream out
//   coeff_fifo,  wr_en_coeff,  last_coeff,  idle_coeff    coefficient stream out
//   busy_o                  either stream in STREAM or LAST
//   done_o                  one-cycle pulse when both streams have reached DONE
module mac_stream_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic                  cfg_sel_i,
  input  logic [ADDR_LINES-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic [ADDR_LINES-1:0] sig_count_i,
  input  logic [ADDR_LINES-1:0] coeff_count_i,
  input  logic                  start_i,
  input  logic                  full_mul,
  output logic [DATA_WIDTH-1:0] signal_fifo,
  output logic                  wr_en_signal,
  output logic                  last_signal,
  output logic                  idle_signal,
  output logic [DATA_WIDTH-1:0] coeff_fifo,
  output logic                  wr_en_coeff,
  output logic                  last_coeff,
  output logic                  idle_coeff,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = 2 ** ADDR_LINES;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LAST   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic start_ok;

  // A start is only accepted when neither stream is active.
  assign start_ok = start_i && !busy_q;

  // Stream 0 = signal, stream 1 = coefficient. Both run the same FSM.
  for (genvar gi = 0; gi < 2; gi++) begin : g_stream
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_LINES-1:0] count_sel;
    state_t                state_q, state_d;
    logic [ADDR_LINES-1:0] count_q, count_d;
    logic [ADDR_LINES-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  last_q, last_d;
    logic                  idle_q, idle_d;

    assign count_sel = (gi == 0) ? sig_count_i : coeff_count_i;

    // Buffer contents are not reset; only the host port writes them.
    always_ff @(posedge clk_i) begin
      if (cfg_we_i && !busy_q && (cfg_sel_i == 1'(gi))) begin
        mem[cfg_addr_i] <= cfg_data_i;
      end
    end

    always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      data_d  = data_q;
      wr_en_d = 1'b0;
      last_d  = last_q;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state_d = ST_STREAM;
            count_d = count_sel;
            idx_d   = '0;
            last_d  = 1'b0;
            // The start edge already issues word 0, so last_* clears on the
            // same edge that the first new word appears.
            if ((count_sel != '0) && !full_mul) begin
              data_d  = mem[ADDR_LINES'(0)];
              wr_en_d = 1'b1;
              idx_d   = ADDR_LINES'(1);
            end
          end
        end
        ST_STREAM: begin
          if (idx_q == count_q) begin
            state_d = ST_LAST;
            last_d  = 1'b1;
          end else if (!full_mul) begin
            data_d  = mem[idx_q];
            wr_en_d = 1'b1;
            idx_d   = ADDR_LINES'(idx_q + 1'b1);
          end
        end
        ST_LAST: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      idle_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        idx_q   <= '0;
        data_q  <= '0;
        wr_en_q <= 1'b0;
        last_q  <= 1'b0;
        idle_q  <= 1'b1;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        idx_q   <= idx_d;
        data_q  <= data_d;
        wr_en_q <= wr_en_d;
        last_q  <= last_d;
        idle_q  <= idle_d;
      end
    end
  end

  always_comb begin
    busy_d = (g_stream[0].state_d == ST_STREAM) || (g_stream[0].state_d == ST_LAST) ||
             (g_stream[1].state_d == ST_STREAM) || (g_stream[1].state_d == ST_LAST);
    // DONE is only left through a new start, so "both DONE next but not both
    // DONE now" marks the edge where the later stream arrives.
    done_d = (g_stream[0].state_d == ST_DONE) && (g_stream[1].state_d == ST_DONE) &&
             !((g_stream[0].state_q == ST_DONE) && (g_stream[1].state_q == ST_DONE));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign signal_fifo  = g_stream[0].data_q;
  assign wr_en_signal = g_stream[0].wr_en_q;
  assign last_signal  = g_stream[0].last_q;
  assign idle_signal  = g_stream[0].idle_q;
  assign coeff_fifo   = g_stream[1].data_q;
  assign wr_en_coeff  = g_stream[1].wr_en_q;
  assign last_coeff   = g_stream[1].last_q;
  assign idle_coeff   = g_stream[1].idle_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb_mac_stream_feeder
//   Self-checking bench for mac_stream_feeder. Expected per-edge behaviour is
//   derived from the list of non-stalled edges: word k of a stream appears on
//   the k-th edge (counting the start edge as 0) at which full_mul was low,
//   last_* rises the edge after the final word (edge 1 for an empty stream),
//   DONE follows one edge later, and done_o pulses when the later stream
//   arrives in DONE.
module tb_mac_stream_feeder;
  localparam int DW = 32;
  localparam int AL = 5;
  localparam int NPAT = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_we_i;
  logic          cfg_sel_i;
  logic [AL-1:0] cfg_addr_i;
  logic [DW-1:0] cfg_data_i;
  logic [AL-1:0] sig_count_i;
  logic [AL-1:0] coeff_count_i;
  logic          start_i;
  logic          full_mul;
  logic [DW-1:0] signal_fifo;
  logic          wr_en_signal;
  logic          last_signal;
  logic          idle_signal;
  logic [DW-1:0] coeff_fifo;
  logic          wr_en_coeff;
  logic          last_coeff;
  logic          idle_coeff;
  logic          busy_o;
  logic          done_o;

  mac_stream_feeder #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .sig_count_i(sig_count_i), .coeff_count_i(coeff_count_i),
    .start_i(start_i), .full_mul(full_mul),
    .signal_fifo(signal_fifo), .wr_en_signal(wr_en_signal), .last_signal(last_signal), .idle_signal(idle_signal),
    .coeff_fifo(coeff_fifo), .wr_en_coeff(wr_en_coeff), .last_coeff(last_coeff), .idle_coeff(idle_coeff),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sig_m   [32];
  logic [31:0] coeff_m [32];
  bit          fm_pat  [NPAT];

  typedef struct {
    int sc;
    int cc;
    int stall_at;
    int stall_len;
    bit poke;
    int exp_sw;
    int exp_cw;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, e, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_signal_fifo"}, -1, signal_fifo, 32'h0);
    chk({tag, "_coeff_fifo"}, -1, coeff_fifo, 32'h0);
    chk({tag, "_wr_en_signal"}, -1, wr_en_signal, 0);
    chk({tag, "_wr_en_coeff"}, -1, wr_en_coeff, 0);
    chk({tag, "_last_signal"}, -1, last_signal, 0);
    chk({tag, "_last_coeff"}, -1, last_coeff, 0);
    chk({tag, "_idle_signal"}, -1, idle_signal, 1);
    chk({tag, "_idle_coeff"}, -1, idle_coeff, 1);
    chk({tag, "_busy"}, -1, busy_o, 0);
    chk({tag, "_done"}, -1, done_o, 0);
  endtask

  task automatic cfg_write(input bit sel, input int addr, input logic [31:0] d);
    cfg_we_i   = 1'b1;
    cfg_sel_i  = sel;
    cfg_addr_i = AL'(addr);
    cfg_data_i = d;
    tick();
    cfg_we_i   = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 32; i++) begin
      cfg_write(1'b0, i, sig_m[i]);
      cfg_write(1'b1, i, coeff_m[i]);
    end
  endtask

  task automatic clear_pat();
    for (int i = 0; i < NPAT; i++) fm_pat[i] = 1'b0;
  endtask

  // Start both streams and check every output on every edge until one edge
  // past the done pulse. Optionally pokes a start and a buffer write mid-run.
  task automatic run(input int sc, input int cc, input bit poke,
                     output int sw, output int cw, output int de);
    int ns[$];
    int last_s, last_c, fin, ks, kc;
    ns = {};
    for (int e = 0; e < NPAT; e++) if (!fm_pat[e]) ns.push_back(e);
    last_s = (sc == 0) ? 1 : ns[sc-1] + 1;
    last_c = (cc == 0) ? 1 : ns[cc-1] + 1;
    fin    = ((last_s > last_c) ? last_s : last_c) + 1;
    sw = 0; cw = 0; de = -1;
    sig_count_i   = AL'(sc);
    coeff_count_i = AL'(cc);
    full_mul      = fm_pat[0];
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    for (int e = 0; e <= fin + 1; e++) begin
      ks = -1; kc = -1;
      for (int k = 0; k < sc; k++) if (ns[k] == e) ks = k;
      for (int k = 0; k < cc; k++) if (ns[k] == e) kc = k;
      chk("wr_en_signal", e, wr_en_signal, ks >= 0);
      if (ks >= 0) chk("signal_fifo", e, signal_fifo, sig_m[ks]);
      chk("last_signal", e, last_signal, e >= last_s);
      chk("idle_signal", e, idle_signal, e >= last_s + 1);
      chk("wr_en_coeff", e, wr_en_coeff, kc >= 0);
      if (kc >= 0) chk("coeff_fifo", e, coeff_fifo, coeff_m[kc]);
      chk("last_coeff", e, last_coeff, e >= last_c);
      chk("idle_coeff", e, idle_coeff, e >= last_c + 1);
      chk("busy", e, busy_o, e < fin);
      chk("done", e, done_o, e == fin);
      if (wr_en_signal) sw++;
      if (wr_en_coeff) cw++;
      if (done_o && de < 0) de = e;
      full_mul = fm_pat[e+1];
      if (poke && e == 3) begin
        start_i    = 1'b1;
        cfg_we_i   = 1'b1;
        cfg_sel_i  = 1'b0;
        cfg_addr_i = '0;
        cfg_data_i = 32'hDEADBEEF;
      end
      tick();
      start_i  = 1'b0;
      cfg_we_i = 1'b0;
    end
    full_mul = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int sw, cw, de, n_seen, sc, cc;
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_sel_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    sig_count_i = '0; coeff_count_i = '0; start_i = 1'b0; full_mul = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    // Sigmoid samples -5.0 .. +5.0 at the ends; TanH coefficients with 1.0 at addr 30.
    for (int i = 0; i < 32; i++) begin
      sig_m[i]   = (i == 0) ? 32'hC0A00000 : (i == 29) ? 32'h40A00000 : (32'h3E000000 + 32'(i * 4099));
      coeff_m[i] = (i == 30) ? 32'h3F800000 : (32'hBD000000 ^ 32'(i * 7919));
    end
    load_all();

    //           sc  cc  stall_at len poke  sw  cw  done
    vecs[0] = '{30, 31, -1, 0, 1'b0, 30, 31, 32};
    vecs[1] = '{30, 31,  5, 3, 1'b0, 30, 31, 35};
    vecs[2] = '{ 0,  1, -1, 0, 1'b0,  0,  1,  2};
    vecs[3] = '{30, 31, -1, 0, 1'b1, 30, 31, 32};
    vecs[4] = '{30, 31, -1, 0, 1'b0, 30, 31, 32};
    vecs[5] = '{ 5,  2, -1, 0, 1'b0,  5,  2,  6};
    vecs[6] = '{31, 31,  0, 2, 1'b0, 31, 31, 34};

    for (int v = 0; v < 7; v++) begin
      clear_pat();
      if (vecs[v].stall_at >= 0)
        for (int s = 0; s < vecs[v].stall_len; s++) fm_pat[vecs[v].stall_at + s] = 1'b1;
      run(vecs[v].sc, vecs[v].cc, vecs[v].poke, sw, cw, de);
      chk($sformatf("vec%0d_sig_writes", v), -1, sw, vecs[v].exp_sw);
      chk($sformatf("vec%0d_coeff_writes", v), -1, cw, vecs[v].exp_cw);
      chk($sformatf("vec%0d_done_edge", v), -1, de, vecs[v].exp_done);
      $display("vec %0d: sc=%0d cc=%0d sw=%0d cw=%0d done_edge=%0d", v, vecs[v].sc, vecs[v].cc, sw, cw, de);
    end

    // Second start after DONE: last_* held high until the restart edge.
    chk("done_hold_last_signal", -1, last_signal, 1);
    chk("done_hold_last_coeff", -1, last_coeff, 1);
    chk("done_hold_idle_signal", -1, idle_signal, 1);
    clear_pat();
    run(30, 31, 1'b0, sw, cw, de);
    chk("restart_sig_writes", -1, sw, 30);
    chk("restart_coeff_writes", -1, cw, 31);
    $display("restart: sw=%0d cw=%0d done_edge=%0d", sw, cw, de);

    // Reset mid-stream after 10 signal writes.
    sig_count_i = AL'(30); coeff_count_i = AL'(31); full_mul = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_seen = 0;
    for (int e = 0; e < 40 && n_seen < 10; e++) begin
      if (wr_en_signal) n_seen++;
      if (n_seen < 10) tick();
    end
    chk("midreset_writes_seen", -1, n_seen, 10);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("midreset");
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk_reset_vals("after_reset");
    run(30, 31, 1'b0, sw, cw, de);
    chk("replay_sig_writes", -1, sw, 30);
    chk("replay_coeff_writes", -1, cw, 31);
    $display("replay after reset: sw=%0d cw=%0d done_edge=%0d", sw, cw, de);

    // Randomized contents, counts and back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 32; i++) begin
        sig_m[i]   = $urandom;
        coeff_m[i] = $urandom;
      end
      load_all();
      for (int i = 0; i < NPAT; i++) fm_pat[i] = (i < 80) && ($urandom_range(3) == 0);
      sc = $urandom_range(31);
      cc = $urandom_range(31);
      run(sc, cc, 1'b0, sw, cw, de);
      chk($sformatf("rand%0d_sig_writes", r), -1, sw, sc);
      chk($sformatf("rand%0d_coeff_writes", r), -1, cw, cc);
      $display("rand %0d: sc=%0d cc=%0d sw=%0d cw=%0d done_edge=%0d", r, sc, cc, sw, cw, de);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
